// File: rtl/keypad_timer_entry_ctrl.sv
// rtl/keypad_timer_entry_ctrl.sv - keypad digit debounce, MM:SS BCD entry and timer load sequencing
module keypad_timer_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       key_none,
   input  logic       start,
   input  logic       clear,
   input  logic       lock,
   output logic       enc_mask,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic [2:0] digit_count,
   output logic       key_ack,
   output logic       load,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, PRESS_DB, ACCEPT, RELEASE_DB} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       cand, cand_nx;
   logic [15:0]      digits, digits_nx;
   logic [2:0]       count, count_nx;
   logic             key_ack_nx, load_nx, err_nx;
   logic             start_en, time_ok, cnt_last;

   assign start_en = start & ~lock;
   // Any nonzero MM:SS with seconds tens <= 5 is a loadable time.
   assign time_ok  = (digits[7:4] <= 4'd5) && (digits != 16'h0000);
   assign cnt_last = (cnt == CNT_LAST);

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      cand_nx    = cand;
      digits_nx  = digits;
      count_nx   = count;
      key_ack_nx = 1'b0;
      load_nx    = 1'b0;
      err_nx     = 1'b0;

      case (state)
         IDLE: begin
            if (!key_none && !lock && (key_code <= 4'd9)) begin
               cand_nx  = key_code;
               cnt_nx   = '0;
               state_nx = PRESS_DB;
            end
         end
         PRESS_DB: begin
            if (key_none || (key_code != cand) || lock) begin
               state_nx = IDLE;
            end else if (cnt_last) begin
               state_nx = ACCEPT;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         ACCEPT: begin
            state_nx = RELEASE_DB;
            cnt_nx   = '0;
            // A coinciding start wins; the digit is dropped, not deferred.
            if ((count < 3'd4) && !start_en) begin
               digits_nx  = {digits[11:0], cand};
               count_nx   = count + 3'd1;
               key_ack_nx = 1'b1;
            end
         end
         RELEASE_DB: begin
            if (!key_none) begin
               cnt_nx = '0;
            end else if (cnt_last) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (start_en) begin
         if (time_ok) begin
            load_nx  = 1'b1;
            count_nx = 3'd0;
         end else begin
            err_nx = 1'b1;
         end
      end

      if (clear) begin
         digits_nx  = 16'h0000;
         count_nx   = 3'd0;
         key_ack_nx = 1'b0;
         load_nx    = 1'b0;
         err_nx     = 1'b0;
         cnt_nx     = '0;
         // A key still held at clear must be released before it can count again.
         state_nx   = key_none ? IDLE : RELEASE_DB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         cand     <= 4'd0;
         digits   <= 16'h0000;
         count    <= 3'd0;
         key_ack  <= 1'b0;
         load     <= 1'b0;
         err      <= 1'b0;
         enc_mask <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         cand     <= cand_nx;
         digits   <= digits_nx;
         count    <= count_nx;
         key_ack  <= key_ack_nx;
         load     <= load_nx;
         err      <= err_nx;
         enc_mask <= lock;
      end
   end

   assign min_tens    = digits[15:12];
   assign min_units   = digits[11:8];
   assign sec_tens    = digits[7:4];
   assign sec_units   = digits[3:0];
   assign digit_count = count;

endmodule

// File: tb/tb_keypad_timer_entry_ctrl.sv
// tb/tb_keypad_timer_entry_ctrl.sv - randomized and scenario bench for keypad_timer_entry_ctrl
module tb_keypad_timer_entry_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst, key_none, start, clear, lock;
   logic [3:0] key_code;
   logic       enc_mask, key_ack, load, err;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic [2:0] digit_count;

   keypad_timer_entry_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
      .clk(clk), .rst(rst), .key_code(key_code), .key_none(key_none),
      .start(start), .clear(clear), .lock(lock), .enc_mask(enc_mask),
      .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
      .sec_units(sec_units), .digit_count(digit_count), .key_ack(key_ack),
      .load(load), .err(err)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int miss_cnt = 0;
   int ack_seen, load_seen, err_seen;

   // Reference: four decimal digits, a count, and run-length bookkeeping for
   // how long the current key has been steady or the keypad has been quiet.
   int  md[4];
   int  mcount, cand, run, rel_run;
   bit  pending, need_rel, mack, mload, merr, mmask;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      bit st_ok;
      int mm, ss;
      if (rst) begin
         for (int i = 0; i < 4; i++) md[i] = 0;
         mcount = 0; run = 0; rel_run = 0; pending = 0; need_rel = 0;
         mack = 0; mload = 0; merr = 0; mmask = 0; cand = 0;
         return;
      end
      mack = 0; mload = 0; merr = 0;
      mmask = lock;
      if (clear) begin
         for (int i = 0; i < 4; i++) md[i] = 0;
         mcount = 0; run = 0; pending = 0; rel_run = 0;
         need_rel = !key_none;
         return;
      end
      st_ok = start && !lock;
      if (st_ok) begin
         mm = md[0] * 10 + md[1];
         ss = md[2] * 10 + md[3];
         if (md[2] <= 5 && (mm * 60 + ss) > 0) begin
            mload = 1; mcount = 0;
         end else begin
            merr = 1;
         end
      end
      if (pending) begin
         if (!st_ok && mcount < 4) begin
            md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = cand;
            mcount++; mack = 1;
         end
         pending = 0; need_rel = 1; rel_run = 0;
      end else if (need_rel) begin
         if (key_none) begin
            rel_run++;
            if (rel_run == D) begin need_rel = 0; rel_run = 0; end
         end else begin
            rel_run = 0;
         end
      end else if (run == 0) begin
         if (!key_none && !lock && key_code <= 9) begin
            cand = int'(key_code); run = 1;
         end
      end else begin
         if (key_none || int'(key_code) != cand || lock) run = 0;
         else if (run == D) begin pending = 1; run = 0; end
         else run++;
      end
   endtask

   task automatic compare();
      check("enc_mask", 32'(enc_mask), 32'(mmask));
      check("digits", 32'({min_tens, min_units, sec_tens, sec_units}),
            32'(md[0] * 4096 + md[1] * 256 + md[2] * 16 + md[3]));
      check("digit_count", 32'(digit_count), 32'(mcount));
      check("key_ack", 32'(key_ack), 32'(mack));
      check("load", 32'(load), 32'(mload));
      check("err", 32'(err), 32'(merr));
      if (key_ack === 1'b1) ack_seen++;
      if (load === 1'b1) load_seen++;
      if (err === 1'b1) err_seen++;
   endtask

   task automatic cyc(input bit kn, input logic [3:0] kc, input bit st, input bit cl,
                      input bit lk, input bit r);
      key_none = kn; key_code = kc; start = st; clear = cl; lock = lk; rst = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic press(input int k, input int hold, input int rel);
      for (int i = 0; i < hold; i++) cyc(1'b0, 4'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < rel; i++) cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n, input bit st, input bit cl);
      cyc(1'b1, 4'd0, st, cl, 1'b0, 1'b0);
      for (int i = 1; i < n; i++) cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bit lk_r;
      int kc, kc2, hold, rel;
      rst = 1'b1; key_none = 1'b1; key_code = 4'd0; start = 1'b0; clear = 1'b0; lock = 1'b0;
      @(negedge clk);
      cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_digits", 32'({min_tens, min_units, sec_tens, sec_units}), 32'h0);
      check("rst_count", 32'(digit_count), 32'd0);

      ack_seen = 0;
      press(5, 10, 10);
      check("s1_ack", 32'(ack_seen), 32'd1);
      check("s1_digits", 32'({min_tens, min_units, sec_tens, sec_units}), 32'h0005);
      check("s1_count", 32'(digit_count), 32'd1);

      idle(1, 1'b0, 1'b1);
      press(1, 8, 8); press(3, 8, 8); press(0, 8, 8);
      load_seen = 0;
      idle(2, 1'b1, 1'b0);
      check("s2_digits", 32'({min_tens, min_units, sec_tens, sec_units}), 32'h0130);
      check("s2_count", 32'(digit_count), 32'd0);
      check("s2_load", 32'(load_seen), 32'd1);

      idle(1, 1'b0, 1'b1);
      ack_seen = 0;
      for (int i = 0; i < 20; i++) cyc(((i / 2) % 2) != 0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8, 1'b0, 1'b0);
      check("s3_ack", 32'(ack_seen), 32'd0);
      check("s3_digits", 32'({min_tens, min_units, sec_tens, sec_units}), 32'h0);

      press(9, 8, 8); press(9, 8, 8);
      err_seen = 0; load_seen = 0;
      idle(2, 1'b1, 1'b0);
      check("s4_err", 32'(err_seen), 32'd1);
      check("s4_load", 32'(load_seen), 32'd0);
      check("s4_sec_tens", 32'(sec_tens), 32'd9);
      idle(1, 1'b0, 1'b1);
      check("s4_clear", 32'({min_tens, min_units, sec_tens, sec_units}), 32'h0);
      err_seen = 0;
      idle(2, 1'b1, 1'b0);
      check("s4_zero_err", 32'(err_seen), 32'd1);

      ack_seen = 0;
      for (int k = 1; k <= 5; k++) press(k, 8, 8);
      check("s5_digits", 32'({min_tens, min_units, sec_tens, sec_units}), 32'h1234);
      check("s5_count", 32'(digit_count), 32'd4);
      check("s5_ack", 32'(ack_seen), 32'd4);

      idle(1, 1'b0, 1'b1);
      ack_seen = 0; load_seen = 0; err_seen = 0;
      cyc(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      check("s6_mask", 32'(enc_mask), 32'd1);
      check("s6_ack", 32'(ack_seen), 32'd0);
      cyc(1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      check("s6_lock_start", 32'(load_seen + err_seen), 32'd0);
      idle(6, 1'b0, 1'b0);
      press(8, 7, 2);
      cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("s6_rst", 32'({enc_mask, key_ack, load, err, digit_count, min_tens, min_units,
                           sec_tens, sec_units}), 32'h0);

      lk_r = 1'b0;
      for (int seg = 0; seg < 400; seg++) begin
         if ($urandom_range(0, 15) == 0) lk_r = ~lk_r;
         kc = $urandom_range(0, 11);
         kc2 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : kc;
         hold = $urandom_range(1, 9);
         rel = $urandom_range(1, 8);
         for (int i = 0; i < hold + rel; i++) begin
            cyc(i >= hold, (i < hold / 2) ? 4'(kc) : 4'(kc2),
                $urandom_range(0, 24) == 0, $urandom_range(0, 69) == 0,
                lk_r, $urandom_range(0, 499) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/keypad_timer_entry_ctrl.md
Name: keypad_timer_entry_ctrl

Overview:
Sequences the keypad priority-encoder output into the microwave cook-time register.
- Debounces each key press and accepts exactly one digit per press.
- Shifts accepted digits into a 4-digit BCD MM:SS buffer.
- Validates the time and issues a one-cycle load to the countdown timer on start.
- Masks the encoder while cooking is in progress.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (synthesis top overrides, e.g. 500000).
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_code  input  4  encoder digit code, 0..9
key_none  input  1  encoder Cn: 1 = no key pressed, or encoder masked
start  input  1  one-cycle start request (already synchronized)
clear  input  1  one-cycle clear request (already synchronized)
lock  input  1  1 = oven running; keypad entry disabled
enc_mask  output  1  drives encoder en; equals lock, registered
min_tens  output  4  BCD digit 3
min_units  output  4  BCD digit 2
sec_tens  output  4  BCD digit 1
sec_units  output  4  BCD digit 0
digit_count  output  3  digits entered, 0..4
key_ack  output  1  one-cycle pulse when a digit is accepted
load  output  1  one-cycle pulse: time is valid, timer must load the digits
err  output  1  one-cycle pulse: start rejected

Behaviour:
- Reset (sync): state IDLE; all digits 0; digit_count 0; key_ack, load and err 0; enc_mask 0; debounce counter 0.
- FSM states: IDLE, PRESS_DB, ACCEPT, RELEASE_DB.
  - IDLE: when key_none=0 and lock=0, latch key_code into cand, clear counter, go to PRESS_DB.
  - PRESS_DB: count while key_none=0 and key_code==cand.
    - If key_none=1 or key_code changes, return to IDLE with no accept.
    - When counter reaches DEBOUNCE_CYCLES-1, go to ACCEPT.
  - ACCEPT (single cycle):
    - If digit_count<4: shift {min_tens,min_units,sec_tens,sec_units} <= {min_units,sec_tens,sec_units,cand}; digit_count+1; key_ack=1.
    - If digit_count==4: ignore the digit; no key_ack.
    - Always go to RELEASE_DB.
  - RELEASE_DB: count consecutive key_none=1 cycles; any key_none=0 restarts the count. Return to IDLE after DEBOUNCE_CYCLES.
- Press-to-accept latency: a press held stable from cycle t produces key_ack at t+DEBOUNCE_CYCLES+1 (±1 for the IDLE latch).
- A held key is never auto-repeated.
- key_code values above 9 with key_none=0 are ignored: return to IDLE with no shift.
- start (evaluated in any state):
  - Valid when sec_tens<=5 and the time is nonzero. Then load=1 in the next cycle, digits hold their value, and digit_count resets to 0.
  - Otherwise err=1 in the next cycle and the digits are unchanged.
  - start is ignored while lock=1: no load, no err.
- clear: digits 0, digit_count 0, FSM to RELEASE_DB if a key is held, else IDLE. clear is allowed while lock=1.
- Same-cycle priority: rst > clear > start > ACCEPT shift. If start and ACCEPT coincide, start is evaluated on the pre-shift digits and the shift is dropped.
- lock rising: abort PRESS_DB to IDLE with no accept. enc_mask follows lock one cycle later. While lock=1, IDLE does not leave IDLE.
- Digits are never modified by load; the timer owns countdown state.
- Outputs are registered; load, err and key_ack are never asserted in two consecutive cycles by a single event.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, then press key 5 for 10 cycles, release 10 cycles -> one key_ack; sec_units=5; digit_count=1; other digits 0.
2. Enter 1,3,0 with clean presses, then start -> digits 01:30; load pulses once; digit_count=0.
3. Bounce: key_none toggles 0/1 every 2 cycles for 20 cycles, then stable release -> no key_ack; digits unchanged.
4. Enter 9,9 then start -> sec_tens=9; err pulses; no load. Enter clear -> all digits 0. Start with 00:00 -> err.
5. Enter 1,2,3,4,5 -> digits 12:34; fifth press gives no key_ack; digit_count=4.
6. Press 7 and raise lock at cycle 2 of PRESS_DB -> no accept; enc_mask=1 next cycle. start while lock=1 -> neither load nor err. rst asserted mid-RELEASE_DB -> all outputs 0 next cycle.
